// File: rtl/boot_loader_ctrl.sv
// Boot loader: holds the core in reset while a length-prefixed little-endian
// word stream arrives over the UART, writes it to instruction ROM, then releases the core.
module boot_loader_ctrl #(
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
    parameter int          MAX_WORDS      = 1024,
    parameter int          TIMEOUT_CYCLES = 1000000
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic [7:0]  rx_data_i,
    input  logic        rx_valid_i,
    input  logic        load_req_i,
    output logic        rom_wr_en_o,
    output logic [31:0] rom_wr_addr_o,
    output logic [31:0] rom_wr_data_o,
    output logic        cpu_reset_n_o,
    output logic        busy_o,
    output logic        error_o,
    output logic [15:0] words_loaded_o
);

    typedef enum logic [1:0] {
        ST_LEN   = 2'd0,
        ST_DATA  = 2'd1,
        ST_RUN   = 2'd2,
        ST_ERROR = 2'd3
    } state_t;

    state_t      state_r;
    logic [1:0]  byte_cnt_r;
    logic [31:0] asm_r;
    logic [15:0] word_count_r;
    logic [15:0] index_r;
    logic [31:0] timeout_r;

    logic [31:0] full_word_s;
    logic        timing_s;
    logic        tmo_hit_s;
    logic [31:0] wr_addr_s;

    // A zero-length or oversize image can never be loaded, so it is rejected up front.
    function automatic logic len_bad(input logic [31:0] wc);
        return (wc == 32'd0) || (wc > 32'(MAX_WORDS));
    endfunction

    assign full_word_s = {rx_data_i, asm_r[23:0]};
    assign timing_s    = (state_r == ST_DATA) || ((state_r == ST_LEN) && (byte_cnt_r != 2'd0));
    assign tmo_hit_s   = timing_s && (timeout_r >= 32'(TIMEOUT_CYCLES - 1));
    assign wr_addr_s   = BASE_ADDR + {14'd0, index_r, 2'b00};

    // Load sequencer: state, byte assembly, timeout and all registered outputs.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_r        <= ST_LEN;
            byte_cnt_r     <= 2'd0;
            asm_r          <= 32'd0;
            word_count_r   <= 16'd0;
            index_r        <= 16'd0;
            timeout_r      <= 32'd0;
            rom_wr_en_o    <= 1'b0;
            rom_wr_addr_o  <= 32'd0;
            rom_wr_data_o  <= 32'd0;
            cpu_reset_n_o  <= 1'b0;
            busy_o         <= 1'b1;
            error_o        <= 1'b0;
            words_loaded_o <= 16'd0;
        end else begin
            rom_wr_en_o <= 1'b0;
            // A load request wins over any byte or timeout arriving in the same cycle.
            if (load_req_i) begin
                state_r        <= ST_LEN;
                byte_cnt_r     <= 2'd0;
                index_r        <= 16'd0;
                timeout_r      <= 32'd0;
                words_loaded_o <= 16'd0;
                cpu_reset_n_o  <= 1'b0;
                busy_o         <= 1'b1;
                error_o        <= 1'b0;
            end else begin
                case (state_r)
                    ST_LEN, ST_DATA: begin
                        cpu_reset_n_o <= 1'b0;
                        if (rx_valid_i) begin
                            timeout_r                     <= 32'd0;
                            byte_cnt_r                    <= byte_cnt_r + 2'd1;
                            asm_r[{byte_cnt_r, 3'b000} +: 8] <= rx_data_i;
                            if (byte_cnt_r == 2'd3) begin
                                if (state_r == ST_LEN) begin
                                    if (len_bad(full_word_s)) begin
                                        state_r <= ST_ERROR;
                                        error_o <= 1'b1;
                                        busy_o  <= 1'b0;
                                    end else begin
                                        state_r      <= ST_DATA;
                                        word_count_r <= full_word_s[15:0];
                                        index_r      <= 16'd0;
                                    end
                                end else begin
                                    rom_wr_en_o    <= 1'b1;
                                    rom_wr_addr_o  <= wr_addr_s;
                                    rom_wr_data_o  <= full_word_s;
                                    index_r        <= index_r + 16'd1;
                                    words_loaded_o <= index_r + 16'd1;
                                    if (index_r == (word_count_r - 16'd1)) begin
                                        state_r <= ST_RUN;
                                        busy_o  <= 1'b0;
                                    end else begin
                                        state_r <= ST_DATA;
                                    end
                                end
                            end else begin
                                state_r <= state_r;
                            end
                        end else if (tmo_hit_s) begin
                            // Partial word is dropped; nothing is written.
                            state_r    <= ST_ERROR;
                            error_o    <= 1'b1;
                            busy_o     <= 1'b0;
                            byte_cnt_r <= 2'd0;
                            timeout_r  <= 32'd0;
                        end else if (timing_s) begin
                            timeout_r <= timeout_r + 32'd1;
                        end else begin
                            timeout_r <= 32'd0;
                        end
                    end
                    ST_RUN: begin
                        cpu_reset_n_o <= 1'b1;
                        busy_o        <= 1'b0;
                        error_o       <= 1'b0;
                    end
                    ST_ERROR: begin
                        cpu_reset_n_o <= 1'b0;
                        busy_o        <= 1'b0;
                        error_o       <= 1'b1;
                    end
                    default: begin
                        state_r       <= ST_ERROR;
                        cpu_reset_n_o <= 1'b0;
                        busy_o        <= 1'b0;
                        error_o       <= 1'b1;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_boot_loader_ctrl.sv
// Directed bench for boot_loader_ctrl: checks loads, length errors, timeout,
// reload from RUN and asynchronous reset in the middle of a word.
module tb_boot_loader_ctrl;

    localparam int TMO = 40;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic [7:0]  rx_data_i = 8'd0;
    logic        rx_valid_i = 1'b0;
    logic        load_req_i = 1'b0;
    logic        rom_wr_en_o;
    logic [31:0] rom_wr_addr_o;
    logic [31:0] rom_wr_data_o;
    logic        cpu_reset_n_o;
    logic        busy_o;
    logic        error_o;
    logic [15:0] words_loaded_o;

    int n_cmp = 0;
    int n_err = 0;
    int wr_cnt = 0;
    logic [31:0] wr_addr_q[$];
    logic [31:0] wr_data_q[$];

    boot_loader_ctrl #(
        .BASE_ADDR(32'h0000_0000),
        .MAX_WORDS(1024),
        .TIMEOUT_CYCLES(TMO)
    ) dut (
        .clk(clk),
        .reset_n(reset_n),
        .rx_data_i(rx_data_i),
        .rx_valid_i(rx_valid_i),
        .load_req_i(load_req_i),
        .rom_wr_en_o(rom_wr_en_o),
        .rom_wr_addr_o(rom_wr_addr_o),
        .rom_wr_data_o(rom_wr_data_o),
        .cpu_reset_n_o(cpu_reset_n_o),
        .busy_o(busy_o),
        .error_o(error_o),
        .words_loaded_o(words_loaded_o)
    );

    always #5 clk = ~clk;

    // Record every write strobe, including any that might appear during reset.
    always @(negedge clk) begin
        if (rom_wr_en_o === 1'b1) begin
            wr_cnt = wr_cnt + 1;
            wr_addr_q.push_back(rom_wr_addr_o);
            wr_data_q.push_back(rom_wr_data_o);
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic cycles(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        rx_data_i  = b;
        rx_valid_i = 1'b1;
        @(negedge clk);
        rx_valid_i = 1'b0;
    endtask

    task automatic send_word(input logic [31:0] w);
        logic [31:0] t;
        t = w;
        for (int k = 0; k < 4; k++) send_byte(t[8*k +: 8]);
    endtask

    task automatic pulse_load_req();
        @(negedge clk);
        load_req_i = 1'b1;
        @(negedge clk);
        load_req_i = 1'b0;
    endtask

    initial begin
        // Reset state
        cycles(2);
        chk("rst_busy", 32'(busy_o), 32'd1);
        chk("rst_cpu_reset_n", 32'(cpu_reset_n_o), 32'd0);
        chk("rst_error", 32'(error_o), 32'd0);
        chk("rst_wr_en", 32'(rom_wr_en_o), 32'd0);
        chk("rst_addr", rom_wr_addr_o, 32'd0);
        chk("rst_data", rom_wr_data_o, 32'd0);
        chk("rst_words", 32'(words_loaded_o), 32'd0);
        @(negedge clk);
        reset_n = 1'b1;
        cycles(2);

        // Two-word load with latency check on the final byte
        send_word(32'd2);
        send_word(32'h1234_5678);
        send_byte(8'hEF); send_byte(8'hBE); send_byte(8'hAD); send_byte(8'hDE);
        chk("w2_wr_en_t1", 32'(rom_wr_en_o), 32'd1);
        chk("w2_addr_t1", rom_wr_addr_o, 32'h0000_0004);
        chk("w2_data_t1", rom_wr_data_o, 32'hDEAD_BEEF);
        chk("w2_busy_t1", 32'(busy_o), 32'd0);
        chk("w2_cpu_rst_t1", 32'(cpu_reset_n_o), 32'd0);
        @(negedge clk);
        chk("w2_cpu_rst_t2", 32'(cpu_reset_n_o), 32'd1);
        chk("w2_wr_en_t2", 32'(rom_wr_en_o), 32'd0);
        chk("w2_words", 32'(words_loaded_o), 32'd2);
        cycles(2);
        chk("w2_wr_cnt", 32'(wr_cnt), 32'd2);
        if (wr_cnt >= 2) begin
            chk("w2_addr0", wr_addr_q[0], 32'h0000_0000);
            chk("w2_data0", wr_data_q[0], 32'h1234_5678);
            chk("w2_addr1", wr_addr_q[1], 32'h0000_0004);
        end

        // Bytes in RUN are ignored
        send_word(32'hFFFF_FFFF);
        chk("run_ignore_wr", 32'(wr_cnt), 32'd2);
        chk("run_still_released", 32'(cpu_reset_n_o), 32'd1);

        // Reload from RUN with a simultaneous byte that must be discarded
        @(negedge clk);
        load_req_i = 1'b1;
        rx_valid_i = 1'b1;
        rx_data_i  = 8'hAA;
        @(negedge clk);
        load_req_i = 1'b0;
        rx_valid_i = 1'b0;
        chk("rl_cpu_rst", 32'(cpu_reset_n_o), 32'd0);
        chk("rl_busy", 32'(busy_o), 32'd1);
        chk("rl_words", 32'(words_loaded_o), 32'd0);
        send_word(32'd1);
        send_word(32'h4433_2211);
        chk("rl_addr", rom_wr_addr_o, 32'h0000_0000);
        chk("rl_data", rom_wr_data_o, 32'h4433_2211);
        cycles(2);
        chk("rl_cpu_rst_up", 32'(cpu_reset_n_o), 32'd1);
        chk("rl_words1", 32'(words_loaded_o), 32'd1);
        chk("rl_wr_cnt", 32'(wr_cnt), 32'd3);

        // Zero length goes to ERROR, recovery via load_req
        pulse_load_req();
        send_word(32'd0);
        chk("bad_error", 32'(error_o), 32'd1);
        chk("bad_busy", 32'(busy_o), 32'd0);
        cycles(2);
        chk("bad_cpu_rst", 32'(cpu_reset_n_o), 32'd0);
        chk("bad_wr_cnt", 32'(wr_cnt), 32'd3);
        pulse_load_req();
        chk("bad_clr_error", 32'(error_o), 32'd0);
        chk("bad_clr_busy", 32'(busy_o), 32'd1);
        send_word(32'd1);
        send_word(32'h0BAD_F00D);
        cycles(2);
        chk("bad_rec_wr_cnt", 32'(wr_cnt), 32'd4);
        chk("bad_rec_data", rom_wr_data_o, 32'h0BAD_F00D);
        chk("bad_rec_cpu_rst", 32'(cpu_reset_n_o), 32'd1);

        // Boundary: MAX_WORDS accepted, MAX_WORDS+1 rejected
        pulse_load_req();
        send_word(32'd1024);
        chk("max_error", 32'(error_o), 32'd0);
        chk("max_busy", 32'(busy_o), 32'd1);
        pulse_load_req();
        send_word(32'd1025);
        chk("over_error", 32'(error_o), 32'd1);
        chk("over_busy", 32'(busy_o), 32'd0);

        // Timeout during a partial word
        pulse_load_req();
        send_word(32'd1);
        send_byte(8'h01);
        send_byte(8'h02);
        cycles(TMO / 2);
        chk("tmo_not_yet", 32'(error_o), 32'd0);
        cycles(TMO);
        chk("tmo_error", 32'(error_o), 32'd1);
        send_byte(8'h03);
        send_byte(8'h04);
        cycles(2);
        chk("tmo_late_error", 32'(error_o), 32'd1);
        chk("tmo_wr_cnt", 32'(wr_cnt), 32'd4);

        // Asynchronous reset after three data bytes
        pulse_load_req();
        send_word(32'd1);
        send_byte(8'h99); send_byte(8'h98); send_byte(8'h97);
        #2;
        reset_n = 1'b0;
        #1;
        chk("ar_busy", 32'(busy_o), 32'd1);
        chk("ar_cpu_rst", 32'(cpu_reset_n_o), 32'd0);
        chk("ar_words", 32'(words_loaded_o), 32'd0);
        chk("ar_wr_en", 32'(rom_wr_en_o), 32'd0);
        chk("ar_data", rom_wr_data_o, 32'd0);
        cycles(3);
        chk("ar_wr_cnt", 32'(wr_cnt), 32'd4);
        reset_n = 1'b1;
        cycles(1);
        send_word(32'd1);
        send_byte(8'h55); send_byte(8'h66); send_byte(8'h77); send_byte(8'h88);
        chk("ar_new_addr", rom_wr_addr_o, 32'h0000_0000);
        chk("ar_new_data", rom_wr_data_o, 32'h8877_6655);
        cycles(2);
        chk("ar_new_wr_cnt", 32'(wr_cnt), 32'd5);
        chk("ar_new_cpu_rst", 32'(cpu_reset_n_o), 32'd1);
        chk("ar_new_words", 32'(words_loaded_o), 32'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
